// File: rtl/stc_prog_if.sv
// stc_prog_if -- bundles the video stream, breakpoint-table configuration and
// status signals of stc_prog.
//   master : stimulus side, drives trig/video/config and observes outputs
//   slave  : stc_prog side
// Ports (slave view):
//   trig          in   sweep start request (level)
//   vid_in        in   DATA_W unsigned sample, qualified by vid_valid
//   vid_out       out  DATA_W gain-scaled sample, qualified by vid_out_valid
//   cfg_we        in   table entry write strobe (cfg_addr, cfg_idx, cfg_gain)
//   cfg_len_we    in   table length write strobe (cfg_len)
//   sweep_active  out  high while sweeping
//   cfg_err       out  one-cycle pulse when a config write is dropped
interface stc_prog_if #(
    parameter int DATA_W = 12,
    parameter int GAIN_W = 12,
    parameter int CNT_W  = 12,
    parameter int BP_AW  = 6
);
    logic              trig;
    logic [DATA_W-1:0] vid_in;
    logic              vid_valid;
    logic [DATA_W-1:0] vid_out;
    logic              vid_out_valid;
    logic              cfg_we;
    logic [BP_AW-1:0]  cfg_addr;
    logic [CNT_W-1:0]  cfg_idx;
    logic [GAIN_W-1:0] cfg_gain;
    logic              cfg_len_we;
    logic [BP_AW:0]    cfg_len;
    logic              sweep_active;
    logic              cfg_err;

    modport master (
        output trig, vid_in, vid_valid, cfg_we, cfg_addr, cfg_idx, cfg_gain,
               cfg_len_we, cfg_len,
        input  vid_out, vid_out_valid, sweep_active, cfg_err
    );

    modport slave (
        input  trig, vid_in, vid_valid, cfg_we, cfg_addr, cfg_idx, cfg_gain,
               cfg_len_we, cfg_len,
        output vid_out, vid_out_valid, sweep_active, cfg_err
    );
endinterface

// File: rtl/stc_prog.sv
// stc_prog -- sample-count-driven programmable gain for a video stream.
// A trigger starts a sweep; every accepted sample advances a counter, and when
// the counter reaches the sample index of the next breakpoint table entry the
// entry's gain becomes the current gain. Samples are scaled by the gain
// (unsigned Q1.(GAIN_W-1)) with saturation through a 2-stage pipeline.
// Ports:
//   clk  in  single clock, rising edge
//   rst  in  asynchronous active-low reset
//   bus  slave modport of stc_prog_if (video, config, status)
module stc_prog #(
    parameter int DATA_W       = 12,
    parameter int GAIN_W       = 12,
    parameter int CNT_W        = 12,
    parameter int SAMPLE_LIMIT = 2626,
    parameter int BP_AW        = 6,
    parameter int RETRIG       = 0
) (
    input logic       clk,
    input logic       rst,
    stc_prog_if.slave bus
);
    localparam int DEPTH  = 1 << BP_AW;
    localparam int PROD_W = DATA_W + GAIN_W;

    localparam logic [0:0]        ST_IDLE  = 1'b0;
    localparam logic [0:0]        ST_SWEEP = 1'b1;
    localparam logic [CNT_W-1:0]  LIMIT    = CNT_W'(SAMPLE_LIMIT);
    localparam logic [GAIN_W-1:0] UNITY    = {1'b1, {(GAIN_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_OUT  = {DATA_W{1'b1}};

    logic [0:0]        state_r;
    logic [CNT_W-1:0]  count_r;
    logic [BP_AW:0]    ptr_r;
    logic [GAIN_W-1:0] gain_cur_r;
    logic [BP_AW:0]    len_r;
    logic [PROD_W-1:0] prod_r;
    logic              v1_r;
    logic [DATA_W-1:0] out_r;
    logic              v2_r;
    logic              cfg_err_r;

    logic [CNT_W-1:0]  idx_mem  [DEPTH];
    logic [GAIN_W-1:0] gain_mem [DEPTH];

    logic              in_sweep_s;
    logic [CNT_W-1:0]  eff_count_s;
    logic [BP_AW:0]    eff_ptr_s;
    logic [CNT_W-1:0]  entry_idx_s;
    logic [GAIN_W-1:0] entry_gain_s;
    logic              match_s;
    logic [GAIN_W-1:0] gain_use_s;
    logic              cfg_req_s;
    logic              cfg_ok_s;
    logic              cfg_drop_s;

    // Drop the Q1 fraction bits and clamp anything above the output range.
    function automatic logic [DATA_W-1:0] sat_scale(input logic [PROD_W-1:0] p);
        logic [PROD_W-1:0] sh;
        sh = p >> (GAIN_W - 1);
        if (|sh[PROD_W-1:DATA_W]) begin
            return MAX_OUT;
        end else begin
            return sh[DATA_W-1:0];
        end
    endfunction

    // Breakpoint match, gain selection and config write qualification.
    always_comb begin
        in_sweep_s   = (state_r == ST_SWEEP);
        eff_count_s  = count_r;
        eff_ptr_s    = ptr_r;
        entry_idx_s  = {CNT_W{1'b0}};
        entry_gain_s = {GAIN_W{1'b0}};
        match_s      = 1'b0;
        gain_use_s   = gain_cur_r;
        cfg_req_s    = bus.cfg_we | bus.cfg_len_we;
        cfg_ok_s     = 1'b0;
        cfg_drop_s   = 1'b0;
        // A retrigger restarts the sweep in this very cycle, so a sample
        // accepted alongside it already sees count 0 and entry 0.
        if (in_sweep_s && (RETRIG != 0) && bus.trig) begin
            eff_count_s = {CNT_W{1'b0}};
            eff_ptr_s   = {(BP_AW+1){1'b0}};
        end else begin
            eff_count_s = count_r;
            eff_ptr_s   = ptr_r;
        end
        entry_idx_s  = idx_mem[eff_ptr_s[BP_AW-1:0]];
        entry_gain_s = gain_mem[eff_ptr_s[BP_AW-1:0]];
        if (in_sweep_s && bus.vid_valid && (eff_ptr_s < len_r) &&
            (eff_count_s == entry_idx_s)) begin
            match_s    = 1'b1;
            gain_use_s = entry_gain_s;
        end else begin
            match_s    = 1'b0;
            gain_use_s = gain_cur_r;
        end
        // The table is only writable while idle and not starting a sweep.
        if (cfg_req_s && !in_sweep_s && !bus.trig) begin
            cfg_ok_s   = 1'b1;
            cfg_drop_s = 1'b0;
        end else begin
            cfg_ok_s   = 1'b0;
            cfg_drop_s = cfg_req_s;
        end
    end

    // Sweep FSM, sample counter, breakpoint pointer, current gain and length.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            count_r    <= LIMIT;
            ptr_r      <= {(BP_AW+1){1'b0}};
            gain_cur_r <= UNITY;
            len_r      <= {(BP_AW+1){1'b0}};
            cfg_err_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.trig) begin
                        state_r <= ST_SWEEP;
                        count_r <= {CNT_W{1'b0}};
                        ptr_r   <= {(BP_AW+1){1'b0}};
                    end else begin
                        count_r <= LIMIT;
                    end
                end
                ST_SWEEP: begin
                    if (bus.vid_valid) begin
                        // The sample taken at the limit is the last of the sweep.
                        if (eff_count_s == LIMIT) begin
                            state_r <= ST_IDLE;
                            count_r <= LIMIT;
                        end else begin
                            count_r <= eff_count_s + CNT_W'(1);
                        end
                    end else begin
                        count_r <= eff_count_s;
                    end
                    ptr_r <= match_s ? (eff_ptr_s + (BP_AW+1)'(1)) : eff_ptr_s;
                end
                default: begin
                    state_r <= ST_IDLE;
                    count_r <= LIMIT;
                    ptr_r   <= {(BP_AW+1){1'b0}};
                end
            endcase
            if (match_s) begin
                gain_cur_r <= entry_gain_s;
            end
            if (cfg_ok_s && bus.cfg_len_we) begin
                len_r <= bus.cfg_len;
            end
            cfg_err_r <= cfg_drop_s;
        end
    end

    // Breakpoint table storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (cfg_ok_s && bus.cfg_we) begin
            idx_mem[bus.cfg_addr]  <= bus.cfg_idx;
            gain_mem[bus.cfg_addr] <= bus.cfg_gain;
        end
    end

    // Two-stage scaling pipeline: multiply, then shift and saturate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_r <= {PROD_W{1'b0}};
            v1_r   <= 1'b0;
            out_r  <= {DATA_W{1'b0}};
            v2_r   <= 1'b0;
        end else begin
            v1_r <= bus.vid_valid;
            if (bus.vid_valid) begin
                prod_r <= PROD_W'(bus.vid_in) * PROD_W'(gain_use_s);
            end
            v2_r <= v1_r;
            if (v1_r) begin
                out_r <= sat_scale(prod_r);
            end
        end
    end

    assign bus.vid_out       = out_r;
    assign bus.vid_out_valid = v2_r;
    assign bus.sweep_active  = (state_r == ST_SWEEP);
    assign bus.cfg_err       = cfg_err_r;
endmodule

// File: tb/tb_stc_prog.sv
// tb_stc_prog -- directed bench for stc_prog. Two instances share one
// stimulus stream: dut0 with RETRIG=0 and dut1 with RETRIG=1. Expected
// outputs are queued per instance when a sample is driven and compared when
// due, two cycles later.
module tb_stc_prog;
    logic clk;
    logic rst;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        logic [11:0] data;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    stc_prog_if #(.DATA_W(12), .GAIN_W(12), .CNT_W(12), .BP_AW(6)) bus0 ();
    stc_prog_if #(.DATA_W(12), .GAIN_W(12), .CNT_W(12), .BP_AW(6)) bus1 ();

    assign bus1.trig       = bus0.trig;
    assign bus1.vid_in     = bus0.vid_in;
    assign bus1.vid_valid  = bus0.vid_valid;
    assign bus1.cfg_we     = bus0.cfg_we;
    assign bus1.cfg_addr   = bus0.cfg_addr;
    assign bus1.cfg_idx    = bus0.cfg_idx;
    assign bus1.cfg_gain   = bus0.cfg_gain;
    assign bus1.cfg_len_we = bus0.cfg_len_we;
    assign bus1.cfg_len    = bus0.cfg_len;

    stc_prog #(.DATA_W(12), .GAIN_W(12), .CNT_W(12), .SAMPLE_LIMIT(2626),
               .BP_AW(6), .RETRIG(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    stc_prog #(.DATA_W(12), .GAIN_W(12), .CNT_W(12), .SAMPLE_LIMIT(2626),
               .BP_AW(6), .RETRIG(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference scaling: v * g / 2^11, clamped to 12 bits.
    function automatic logic [11:0] scale(input logic [11:0] v, input logic [11:0] g);
        logic [23:0] p;
        p = {12'd0, v} * {12'd0, g};
        p = p >> 11;
        if (p > 24'd4095) return 12'hFFF;
        return p[11:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Output scoreboard for dut0.
    always @(negedge clk) begin
        if (q0.size() > 0 && q0[0].due == cyc) begin
            total++;
            assert (bus0.vid_out_valid === 1'b1 && bus0.vid_out === q0[0].data)
            else begin
                bad++;
                $error("FAIL out0 cyc=%0d observed valid=%b data=%h expected data=%h",
                       cyc, bus0.vid_out_valid, bus0.vid_out, q0[0].data);
            end
            void'(q0.pop_front());
        end else begin
            total++;
            assert (bus0.vid_out_valid === 1'b0)
            else begin
                bad++;
                $error("FAIL quiet0 cyc=%0d observed valid=%b expected valid=0",
                       cyc, bus0.vid_out_valid);
            end
        end
    end

    // Output scoreboard for dut1.
    always @(negedge clk) begin
        if (q1.size() > 0 && q1[0].due == cyc) begin
            total++;
            assert (bus1.vid_out_valid === 1'b1 && bus1.vid_out === q1[0].data)
            else begin
                bad++;
                $error("FAIL out1 cyc=%0d observed valid=%b data=%h expected data=%h",
                       cyc, bus1.vid_out_valid, bus1.vid_out, q1[0].data);
            end
            void'(q1.pop_front());
        end else begin
            total++;
            assert (bus1.vid_out_valid === 1'b0)
            else begin
                bad++;
                $error("FAIL quiet1 cyc=%0d observed valid=%b expected valid=0",
                       cyc, bus1.vid_out_valid);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [11:0] v, input logic [11:0] g0, input logic [11:0] g1);
        bus0.vid_valid = 1'b1;
        bus0.vid_in    = v;
        q0.push_back('{scale(v, g0), cyc + 2});
        q1.push_back('{scale(v, g1), cyc + 2});
        tick();
        bus0.vid_valid = 1'b0;
    endtask

    task automatic wr_entry(input logic [5:0] a, input logic [11:0] idx, input logic [11:0] g);
        bus0.cfg_we   = 1'b1;
        bus0.cfg_addr = a;
        bus0.cfg_idx  = idx;
        bus0.cfg_gain = g;
        tick();
        bus0.cfg_we = 1'b0;
    endtask

    task automatic wr_len(input logic [6:0] n);
        bus0.cfg_len_we = 1'b1;
        bus0.cfg_len    = n;
        tick();
        bus0.cfg_len_we = 1'b0;
    endtask

    task automatic start();
        bus0.trig = 1'b1;
        tick();
        bus0.trig = 1'b0;
    endtask

    initial begin
        logic [11:0] g;
        logic [11:0] v;
        bus0.trig       = 1'b0;
        bus0.vid_in     = 12'h000;
        bus0.vid_valid  = 1'b0;
        bus0.cfg_we     = 1'b0;
        bus0.cfg_addr   = 6'd0;
        bus0.cfg_idx    = 12'd0;
        bus0.cfg_gain   = 12'd0;
        bus0.cfg_len_we = 1'b0;
        bus0.cfg_len    = 7'd0;
        rst = 1'b1;
        #3 rst = 1'b0;
        repeat (3) tick();

        // Reset state.
        chk("rst_out_valid", {31'd0, bus0.vid_out_valid}, 32'd0);
        chk("rst_out", {20'd0, bus0.vid_out}, 32'd0);
        chk("rst_sweep", {31'd0, bus0.sweep_active}, 32'd0);
        chk("rst_cfg_err", {31'd0, bus0.cfg_err}, 32'd0);
        chk("rst_count", {20'd0, dut0.count_r}, 32'd2626);
        rst = 1'b1;
        tick();

        // Unity pass-through in IDLE with an empty table.
        sample(12'hABC, 12'h800, 12'h800);
        sample(12'h000, 12'h800, 12'h800);
        sample(12'hFFF, 12'h800, 12'h800);
        repeat (3) tick();
        chk("unity_sweep", {31'd0, bus0.sweep_active}, 32'd0);

        // Breakpoint sweep with config guard checks.
        wr_entry(6'd0, 12'd0, 12'h001);
        wr_entry(6'd1, 12'd60, 12'h002);
        wr_entry(6'd2, 12'd2600, 12'h800);
        wr_len(7'd3);
        chk("cfg_ok_no_err", {31'd0, bus0.cfg_err}, 32'd0);
        bus0.trig     = 1'b1;
        bus0.cfg_we   = 1'b1;
        bus0.cfg_addr = 6'd1;
        bus0.cfg_idx  = 12'd60;
        bus0.cfg_gain = 12'h7FF;
        tick();
        bus0.trig   = 1'b0;
        bus0.cfg_we = 1'b0;
        chk("trig_sweep", {31'd0, bus0.sweep_active}, 32'd1);
        chk("trig_cfg_err", {31'd0, bus0.cfg_err}, 32'd1);
        for (int i = 0; i <= 2626; i++) begin
            g = (i < 60) ? 12'h001 : ((i < 2600) ? 12'h002 : 12'h800);
            if (i == 59) repeat (3) tick();
            if (i == 30) bus0.cfg_we = 1'b1;
            if (i == 2626) chk("sweep_last", {31'd0, bus0.sweep_active}, 32'd1);
            sample(12'hFFF, g, g);
            bus0.cfg_we = 1'b0;
            if (i == 30) chk("sweep_cfg_err", {31'd0, bus0.cfg_err}, 32'd1);
            if (i == 31) chk("sweep_cfg_err_end", {31'd0, bus0.cfg_err}, 32'd0);
        end
        chk("sweep_done0", {31'd0, bus0.sweep_active}, 32'd0);
        chk("sweep_done1", {31'd0, bus1.sweep_active}, 32'd0);

        // Saturation at gain 0xFFF, gain held in IDLE afterwards.
        wr_entry(6'd0, 12'd0, 12'hFFF);
        wr_len(7'd1);
        start();
        for (int i = 0; i <= 2626; i++) begin
            v = (i == 0) ? 12'hFFF : ((i == 1) ? 12'h400 : 12'h001);
            sample(v, 12'hFFF, 12'hFFF);
        end
        chk("sat_done", {31'd0, bus0.sweep_active}, 32'd0);
        sample(12'h400, 12'hFFF, 12'hFFF);

        // Retrigger at count 100: dut0 ignores it, dut1 restarts.
        wr_entry(6'd0, 12'd0, 12'h400);
        wr_entry(6'd1, 12'd50, 12'h600);
        wr_entry(6'd2, 12'd101, 12'hC00);
        wr_len(7'd3);
        start();
        for (int i = 0; i < 100; i++) begin
            g = (i < 50) ? 12'h400 : 12'h600;
            sample(12'h800, g, g);
        end
        bus0.trig = 1'b1;
        sample(12'h800, 12'h600, 12'h400);
        bus0.trig = 1'b0;
        chk("retrig_sweep1", {31'd0, bus1.sweep_active}, 32'd1);
        for (int j = 1; j <= 2626; j++) begin
            g = (j < 50) ? 12'h400 : ((j < 101) ? 12'h600 : 12'hC00);
            sample(12'h800, 12'hC00, g);
        end
        chk("retrig_done0", {31'd0, bus0.sweep_active}, 32'd0);
        chk("retrig_done1", {31'd0, bus1.sweep_active}, 32'd0);

        // Reset mid-sweep at count 500 with samples in flight.
        start();
        for (int i = 0; i < 500; i++) begin
            g = (i < 50) ? 12'h400 : ((i < 101) ? 12'h600 : 12'hC00);
            sample(12'h100, g, g);
        end
        bus0.vid_valid = 1'b1;
        bus0.vid_in    = 12'h100;
        #1 rst = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        chk("mid_rst_valid", {31'd0, bus0.vid_out_valid}, 32'd0);
        chk("mid_rst_sweep", {31'd0, bus0.sweep_active}, 32'd0);
        chk("mid_rst_count", {20'd0, dut0.count_r}, 32'd2626);
        chk("mid_rst_gain", {20'd0, dut0.gain_cur_r}, 32'h800);
        bus0.vid_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        sample(12'h100, 12'h800, 12'h800);
        start();
        sample(12'h123, 12'h800, 12'h800);
        repeat (4) tick();
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stc_prog.md
STC_PROG -- requirements
Module: stc_prog

Interface
REQ-001 Parameter DATA_W, 12, width of video samples in and out.
REQ-002 Parameter GAIN_W, 12, gain word width; unsigned Q1.(GAIN_W-1), where unity is 2^(GAIN_W-1).
REQ-003 Parameter CNT_W, 12, width of the sample counter.
REQ-004 Parameter SAMPLE_LIMIT, 2626, sweep end count.
REQ-005 Parameter BP_AW, 6, breakpoint table address width; depth is 2^BP_AW.
REQ-006 Parameter RETRIG, 0; when 1, a trigger during a sweep restarts it.
REQ-007 Port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-008 Port rst, input, 1 bit, asynchronous active-low reset.
REQ-009 Port trig, input, 1 bit, sweep start request, sampled synchronously at level.
REQ-010 Port vid_in, input, DATA_W bits, unsigned video sample.
REQ-011 Port vid_valid, input, 1 bit, qualifies vid_in; one sample per asserted cycle.
REQ-012 Port vid_out, output, DATA_W bits, gain-scaled sample.
REQ-013 Port vid_out_valid, output, 1 bit, qualifies vid_out.
REQ-014 Port cfg_we, input, 1 bit, breakpoint table write strobe.
REQ-015 Port cfg_addr, input, BP_AW bits, table entry address.
REQ-016 Port cfg_idx, input, CNT_W bits, breakpoint sample index.
REQ-017 Port cfg_gain, input, GAIN_W bits, breakpoint gain.
REQ-018 Port cfg_len_we, input, 1 bit, strobe to load cfg_len.
REQ-019 Port cfg_len, input, BP_AW+1 bits, number of valid entries, 0 to 2^BP_AW.
REQ-020 Port sweep_active, output, 1 bit, high while in SWEEP.
REQ-021 Port cfg_err, output, 1 bit, one-cycle pulse when a config write is dropped.

Function
REQ-022 The FSM SHALL have two states: IDLE and SWEEP.
REQ-023 In IDLE, the counter SHALL hold SAMPLE_LIMIT.
REQ-024 IDLE SHALL go to SWEEP when trig=1: counter<=0, ptr<=0.
REQ-025 In SWEEP, the counter SHALL increment by 1 per accepted sample (vid_valid=1); it SHALL not advance otherwise.
REQ-026 SWEEP SHALL go to IDLE on the accepted sample at which counter==SAMPLE_LIMIT; the counter holds at SAMPLE_LIMIT with no wrap.
REQ-027 In SWEEP with RETRIG=0, trig SHALL be ignored.
REQ-028 In SWEEP with RETRIG=1, trig SHALL reset counter<=0 and ptr<=0; a sample accepted in the same cycle uses count 0.
REQ-029 Match rule: on an accepted sample in SWEEP with ptr<len and counter==idx[ptr], the sample SHALL use gain[ptr], gain_cur<=gain[ptr], and ptr<=ptr+1.
REQ-030 Otherwise, the sample SHALL use gain_cur.
REQ-031 At most one breakpoint SHALL be consumed per sample.
REQ-032 Entries with idx below the current count SHALL never match, so ptr stalls there; the table must be ascending, and the block does no checking.
REQ-033 The gain applied in IDLE SHALL be gain_cur, which holds the last applied value.
REQ-034 Arithmetic: product = vid_in*gain at full DATA_W+GAIN_W width; result = product >> (GAIN_W-1).
REQ-035 A result above 2^DATA_W-1 SHALL saturate to 2^DATA_W-1.
REQ-036 Pipeline stage 1 SHALL register the product and valid; stage 2 SHALL register the shifted/saturated result and valid.
REQ-037 Latency from vid_valid to vid_out_valid SHALL be exactly 2 cycles, with a throughput of 1 sample per cycle.
REQ-038 vid_out SHALL hold its value when vid_out_valid=0.
REQ-039 Config writes (cfg_we, cfg_len_we) SHALL take effect in IDLE only, and only in cycles where trig=0.
REQ-040 A config write in SWEEP, or in the same cycle as an accepted trig, SHALL be dropped, with cfg_err pulsed for 1 cycle.
REQ-041 If cfg_len=0, the sweep SHALL run at constant gain_cur.

Reset
REQ-042 rst=0 SHALL asynchronously force: state=IDLE, counter=SAMPLE_LIMIT, ptr=0, gain_cur=2^(GAIN_W-1), len=0.
REQ-043 rst=0 SHALL also force vid_out=0, vid_out_valid=0, pipeline valids=0, sweep_active=0, cfg_err=0.
REQ-044 Table contents SHALL be undefined after reset; a bench must write the table before use.
REQ-045 Reset mid-sweep SHALL abort the sweep, discard in-flight samples, and leave no output valid pulse.
REQ-046 Leaving reset SHALL be synchronous to clk, with the first state change no earlier than the first rising edge after rst=1.

Verification
REQ-047 Unity pass-through: reset, cfg_len=0, vid_in=0xABC valid -> vid_out=0xABC 2 cycles later, sweep_active=0.
REQ-048 Breakpoint sweep: table {0:0x001, 60:0x002, 2600:0x800}, len=3, trig, vid_in=0xFFF every cycle.
REQ-049 Expected response to REQ-048: vid_out=0x001 at samples 0-59, 0x003 at 60-2599, 0xFFF from 2600; sweep_active drops after sample 2626.
REQ-050 Saturation: gain 0xFFF, vid_in=0xFFF -> vid_out=0xFFF, with no wrap.
REQ-051 Retrigger: RETRIG=0, trig at count 100 -> count continues to 101. RETRIG=1, trig at count 100 -> next sample at count 0 with entry 0 reapplied.
REQ-052 Config guard: cfg_we during SWEEP -> cfg_err pulses once, table unchanged. cfg_we and trig in the same IDLE cycle -> sweep starts, write dropped.
REQ-053 Reset mid-sweep at count 500 with valid in pipeline -> vid_out_valid=0 immediately, counter=2626, gain_cur=0x800.
